// File: rtl/kgp_pkg.sv
// Shared definitions for the miniRISC boot loader and instruction path.
//   state_t    : loader FSM states
//   WORD_BYTES : bytes per instruction word on the boot stream
//   INSTR_W    : instruction word width, shared with imem and decode
package kgp_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned INSTR_W    = 32;

endpackage

// File: rtl/byte_word_assembler.sv
// Assembles big-endian 32-bit words from a byte stream.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of byte position and shift register
//   byte_en    : a byte transfers this cycle
//   byte_in    : the byte
//   word       : assembled word, valid while word_valid is high
//   word_valid : high in the cycle the 4th byte of a word transfers
module byte_word_assembler
  import kgp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               byte_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [1:0]         cnt;
  // Only the first three bytes need storage; the 4th is used directly.
  logic [INSTR_W-9:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sh  <= '0;
    end else if (byte_en) begin
      cnt <= cnt + 2'd1;
      sh  <= {sh[INSTR_W-17:0], byte_in};
    end
  end

  assign word       = {sh, byte_in};
  assign word_valid = byte_en && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: receives a framed byte stream (4-byte word count N, then N
// big-endian words) and writes it to the instruction memory at consecutive
// word addresses, holding the core in reset until the image is complete.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready : byte stream handshake
//   reload          : restart loading from done or error
//   imem_we/imem_addr/imem_wdata : instruction memory write port
//   cpu_hold        : core reset, high until done
//   done, error     : image loaded / frame rejected
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_program_loader
  import kgp_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);

  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  state_t               state;
  logic [ADDR_W-1:0]    idx;
  logic [ADDR_W:0]      nwords;
  logic [INSTR_W-1:0]   word;
  logic                 word_valid;
  logic                 accept;
  logic                 clr;
`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0]   acc;
`endif

  assign in_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign accept   = in_valid && in_ready;
  assign clr      = reload && ((state == S_DONE) || (state == S_ERR));
  assign cpu_hold = ~done;

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .byte_en    (accept),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_HDR;
      idx        <= '0;
      nwords     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc        <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_HDR: begin
          if (word_valid) begin
            if ({1'b0, word} > CAP) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (word == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
              done  <= 1'b1;
`endif
            end else begin
              state  <= S_DATA;
              idx    <= '0;
              nwords <= word[ADDR_W:0];
            end
          end
        end
        S_DATA: begin
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= idx;
            imem_wdata <= word;
            idx        <= idx + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
            acc        <= acc ^ word;
`endif
            // The state leaves here with the strobe, which stops further
            // bytes; done itself is raised one cycle later in S_DONE so the
            // core is released only after the final write has landed.
            if (({1'b0, idx} + (ADDR_W+1)'(1)) == nwords) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (word_valid) begin
            if (word == acc) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          if (reload) begin
            state <= S_HDR;
            done  <= 1'b0;
            idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc   <= '0;
`endif
          end else begin
            done <= 1'b1;
          end
        end
        S_ERR: begin
          if (reload) begin
            state <= S_HDR;
            error <= 1'b0;
            idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
            acc   <= '0;
`endif
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
